// File: rtl/ps2_rx_event_fifo_if.sv
// Key-event handshake between the PS/2 receiver (master) and its consumer (slave).
// The master presents the FIFO head; the slave answers with evt_ready.
interface ps2_rx_event_fifo_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;

  modport master (
    output evt_valid,
    output evt_code,
    output evt_ext,
    output evt_break,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_code,
    input  evt_ext,
    input  evt_break,
    output evt_ready
  );
endinterface

// File: rtl/ps2_rx_event_fifo.sv
// PS/2 keyboard receiver with event FIFO.
// Raw pins -> synchroniser -> deglitch filter -> falling-edge strobe -> 11-bit frame FSM
// (odd parity, stop bit, inter-bit timeout) -> E0/F0 prefix merge -> show-ahead event FIFO.
module ps2_rx_event_fifo #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2_clk_i,
  input  logic                          ps2_data_i,
  ps2_rx_event_fifo_if.master           evt_if,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          parity_err_o,
  output logic                          frame_err_o,
  output logic                          overflow_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = $clog2(FILTER_LEN);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  // Odd parity holds when the eight data bits plus the parity bit contain an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ((^data) ^ par) == 1'b1;
  endfunction

  // Synchroniser chains and filter state
  logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
  logic [FW-1:0]          clk_cnt_q, data_cnt_q;
  logic                   clk_filt_q, data_filt_q, clk_prev_q;
  logic                   strobe_s;

  // Frame FSM state
  state_t        state_q;
  logic [2:0]    bitcnt_q;
  logic [7:0]    shift_q;
  logic [TW-1:0] timer_q;
  logic          byte_done_q;
  logic          parity_err_q, frame_err_q;
  logic          timeout_s;

  // Prefix flags and FIFO
  logic          ext_q, brk_q;
  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q;
  logic          push_req_s, push_ok_s, pop_s, full_s;

  // Bring both raw pins into the clk domain; idle level of the bus is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q  <= {SYNC_STAGES{1'b1}};
      data_sync_q <= {SYNC_STAGES{1'b1}};
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_i};
    end
  end

  // Deglitch: a filtered level follows its pin only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_cnt_q   <= {FW{1'b0}};
      data_cnt_q  <= {FW{1'b0}};
      clk_filt_q  <= 1'b1;
      data_filt_q <= 1'b1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_prev_q <= clk_filt_q;
      if (clk_sync_q[SYNC_STAGES-1] == clk_filt_q) begin
        clk_cnt_q <= {FW{1'b0}};
      end else if (clk_cnt_q == FLT_LAST) begin
        clk_filt_q <= clk_sync_q[SYNC_STAGES-1];
        clk_cnt_q  <= {FW{1'b0}};
      end else begin
        clk_cnt_q <= clk_cnt_q + FW'(1);
      end
      if (data_sync_q[SYNC_STAGES-1] == data_filt_q) begin
        data_cnt_q <= {FW{1'b0}};
      end else if (data_cnt_q == FLT_LAST) begin
        data_filt_q <= data_sync_q[SYNC_STAGES-1];
        data_cnt_q  <= {FW{1'b0}};
      end else begin
        data_cnt_q <= data_cnt_q + FW'(1);
      end
    end
  end

  assign strobe_s  = clk_prev_q & ~clk_filt_q;
  assign timeout_s = (state_q != ST_IDLE) && (timer_q == TMO_MAX);

  // Frame FSM: steps on each bit strobe; a stalled frame is abandoned when the timer saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      bitcnt_q     <= 3'd0;
      shift_q      <= 8'd0;
      timer_q      <= {TW{1'b0}};
      byte_done_q  <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      byte_done_q  <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if ((state_q == ST_IDLE) || strobe_s) begin
        timer_q <= {TW{1'b0}};
      end else if (timer_q != TMO_MAX) begin
        timer_q <= timer_q + TW'(1);
      end
      if (timeout_s) begin
        frame_err_q <= 1'b1;
        state_q     <= ST_IDLE;
      end else if (strobe_s) begin
        case (state_q)
          ST_IDLE: begin
            if (!data_filt_q) begin
              state_q  <= ST_DATA;
              bitcnt_q <= 3'd0;
            end
          end
          ST_DATA: begin
            shift_q  <= {data_filt_q, shift_q[7:1]};
            bitcnt_q <= bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              state_q <= ST_PARITY;
            end
          end
          ST_PARITY: begin
            if (odd_parity_ok(shift_q, data_filt_q)) begin
              state_q <= ST_STOP;
            end else begin
              parity_err_q <= 1'b1;
              state_q      <= ST_IDLE;
            end
          end
          ST_STOP: begin
            if (data_filt_q) begin
              byte_done_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
            state_q <= ST_IDLE;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Push/pop decisions; a push into a full FIFO survives only when the head leaves in the same cycle.
  always_comb begin
    push_req_s = 1'b0;
    if (byte_done_q && (shift_q != 8'hE0) && (shift_q != 8'hF0)) begin
      push_req_s = 1'b1;
    end else begin
      push_req_s = 1'b0;
    end
    full_s    = (count_q == CNT_FULL);
    pop_s     = (count_q != {CW{1'b0}}) && evt_if.evt_ready;
    push_ok_s = push_req_s && (!full_s || pop_s);
    count_d   = count_q + CW'(push_ok_s) - CW'(pop_s);
  end

  // Prefix flags: E0/F0 arm them in any order, a real byte consumes them, a bad frame discards them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
    end else if (parity_err_q || frame_err_q) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
    end else if (byte_done_q) begin
      if (shift_q == 8'hE0) begin
        ext_q <= 1'b1;
      end else if (shift_q == 8'hF0) begin
        brk_q <= 1'b1;
      end else begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end
    end
  end

  // Event FIFO storage, pointers, occupancy and the overflow pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      count_q    <= {CW{1'b0}};
      overflow_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 10'd0;
      end
    end else begin
      overflow_q <= push_req_s && full_s && !pop_s;
      if (push_ok_s) begin
        mem_q[wr_ptr_q] <= {ext_q, brk_q, shift_q};
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
    end
  end

  assign evt_if.evt_valid = (count_q != {CW{1'b0}});
  assign evt_if.evt_code  = mem_q[rd_ptr_q][7:0];
  assign evt_if.evt_break = mem_q[rd_ptr_q][8];
  assign evt_if.evt_ext   = mem_q[rd_ptr_q][9];
  assign fifo_count_o     = count_q;
  assign parity_err_o     = parity_err_q;
  assign frame_err_o      = frame_err_q;
  assign overflow_o       = overflow_q;

endmodule

// File: tb/tb_ps2_rx_event_fifo.sv
// Directed bench for ps2_rx_event_fifo: bit-banged PS/2 frames, scoreboard queue of expected events.
module tb_ps2_rx_event_fifo;
  localparam int SYNC_STAGES = 2;
  localparam int FILTER_LEN  = 8;
  localparam int TIMEOUT     = 2000;
  localparam int DEPTH       = 4;
  localparam int AW          = $clog2(DEPTH);
  localparam int HALF        = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          ps2_clk;
  logic          ps2_data;
  logic [AW:0]   fifo_count;
  logic          perr, ferr, ovf;

  int n_cmp = 0;
  int n_err = 0;
  int perr_cnt = 0;
  int ferr_cnt = 0;
  int ovf_cnt = 0;
  int base;
  logic [9:0] exp_q[$];

  ps2_rx_event_fifo_if bus();

  ps2_rx_event_fifo #(
    .SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .ps2_clk_i(ps2_clk), .ps2_data_i(ps2_data),
    .evt_if(bus), .fifo_count_o(fifo_count),
    .parity_err_o(perr), .frame_err_o(ferr), .overflow_o(ovf)
  );

  always #5 clk = ~clk;

  // Count cycles in which each pulse output is high.
  always @(posedge clk) begin
    if (perr) perr_cnt <= perr_cnt + 1;
    if (ferr) ferr_cnt <= ferr_cnt + 1;
    if (ovf)  ovf_cnt  <= ovf_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [9:0] sb_pop();
    if (exp_q.size() == 0) return 10'h3FF;
    return exp_q.pop_front();
  endfunction

  // One PS/2 bit: data set while clock high, then clock low. Hooks act after the stop-bit fall.
  task automatic send_bit(input logic b, input bit glitch, input int hook);
    ps2_data = b;
    if (glitch) begin
      repeat (8) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (FILTER_LEN - 1) @(negedge clk);
      ps2_clk = 1'b1;
    end
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    case (hook)
      1: begin
        // raw fall + sync + filter = strobe; +1 byte_done; +1 push
        repeat (11) @(negedge clk);
        check("lat_early", bus.evt_valid, 0);
        @(negedge clk);
        check("lat", bus.evt_valid, 1);
        repeat (HALF - 12) @(negedge clk);
      end
      2: begin
        repeat (11) @(negedge clk);
        check("full_pre", fifo_count, DEPTH);
        check("evt_pushpop", {bus.evt_ext, bus.evt_break, bus.evt_code}, sb_pop());
        bus.evt_ready = 1'b1;
        @(negedge clk);
        bus.evt_ready = 1'b0;
        check("pushpop_count", fifo_count, DEPTH);
        repeat (HALF - 12) @(negedge clk);
      end
      default: repeat (HALF) @(negedge clk);
    endcase
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input logic bad_par, input logic stop_v,
                            input int glitch_bit, input int hook);
    logic [10:0] bits;
    bits = {stop_v, (~^code) ^ bad_par, code, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(bits[i], (i == glitch_bit), (i == 10) ? hook : 0);
    repeat (10) @(negedge clk);
  endtask

  task automatic send_good(input logic [7:0] code);
    send_frame(code, 1'b0, 1'b1, -1, 0);
  endtask

  // Accept n events, comparing each head against the scoreboard.
  task automatic drain(input int n);
    for (int k = 0; k < n; k++) begin
      int t;
      t = 0;
      while (!bus.evt_valid && t < 3000) begin
        @(negedge clk);
        t++;
      end
      if (!bus.evt_valid) begin
        check("drain_valid", bus.evt_valid, 1);
        return;
      end
      check("evt", {bus.evt_ext, bus.evt_break, bus.evt_code}, sb_pop());
      bus.evt_ready = 1'b1;
      @(negedge clk);
      bus.evt_ready = 1'b0;
    end
    check("drained_count", fifo_count, 0);
    check("sb_left", exp_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; bus.evt_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_count", fifo_count, 0);
    check("rst_valid", bus.evt_valid, 0);
    check("rst_pulses", {perr, ferr, ovf}, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 1: plain make code, with head latency check
    exp_q.push_back({2'b00, 8'h1C});
    send_frame(8'h1C, 1'b0, 1'b1, -1, 1);
    check("t1_count", fifo_count, 1);
    drain(1);

    // 2: prefixes merge into one event, in either order
    exp_q.push_back({2'b11, 8'h75});
    send_good(8'hE0); send_good(8'hF0); send_good(8'h75);
    check("t2_count", fifo_count, 1);
    drain(1);
    exp_q.push_back({2'b11, 8'h6B});
    exp_q.push_back({2'b10, 8'h70});
    exp_q.push_back({2'b00, 8'h1C});
    send_good(8'hF0); send_good(8'hE0); send_good(8'h6B);
    send_good(8'hE0); send_good(8'h70); send_good(8'h1C);
    check("t2b_count", fifo_count, 3);
    drain(3);

    // 3: parity error, then recovery; prefix before bad frame is discarded
    base = perr_cnt;
    send_good(8'hE0);
    send_frame(8'h1C, 1'b1, 1'b1, -1, 0);
    check("t3_perr", perr_cnt - base, 1);
    check("t3_count", fifo_count, 0);
    exp_q.push_back({2'b00, 8'h1C});
    send_good(8'h1C);
    drain(1);

    // 4: short clock glitches in idle (data low) and mid-frame
    base = perr_cnt + ferr_cnt;
    ps2_data = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (FILTER_LEN - 1) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
    exp_q.push_back({2'b00, 8'h5A});
    send_frame(8'h5A, 1'b0, 1'b1, 3, 0);
    drain(1);
    check("t4_errs", perr_cnt + ferr_cnt - base, 0);

    // 5: stalled frame times out; bad stop bit; recovery
    base = ferr_cnt;
    send_bit(1'b0, 0, 0);
    for (int i = 0; i < 5; i++) send_bit(i[0], 0, 0);
    repeat (TIMEOUT + 10) @(negedge clk);
    check("t5_tmo_ferr", ferr_cnt - base, 1);
    check("t5_count", fifo_count, 0);
    send_frame(8'h1C, 1'b0, 1'b0, -1, 0);
    check("t5_stop_ferr", ferr_cnt - base, 2);
    exp_q.push_back({2'b00, 8'h1C});
    send_good(8'h1C);
    drain(1);

    // 6: overflow when full, then push-while-full-with-pop
    base = ovf_cnt;
    for (int i = 0; i <= DEPTH; i++) begin
      if (i < DEPTH) exp_q.push_back({2'b00, 8'h11 + 8'(i)});
      send_good(8'h11 + 8'(i));
    end
    check("t6_count", fifo_count, DEPTH);
    check("t6_ovf", ovf_cnt - base, 1);
    drain(DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      exp_q.push_back({2'b00, 8'h21 + 8'(i)});
      send_good(8'h21 + 8'(i));
    end
    base = ovf_cnt;
    exp_q.push_back({2'b00, 8'h25});
    send_frame(8'h25, 1'b0, 1'b1, -1, 2);
    check("t6_pushpop_ovf", ovf_cnt - base, 0);
    drain(DEPTH);

    // Reset in the middle of a frame with events queued
    send_good(8'h31); send_good(8'h32);
    send_bit(1'b0, 0, 0); send_bit(1'b1, 0, 0); send_bit(1'b0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_count", fifo_count, 0);
    check("mrst_valid", bus.evt_valid, 0);
    check("mrst_evt", {bus.evt_ext, bus.evt_break, bus.evt_code}, 0);
    check("mrst_pulses", {perr, ferr, ovf}, 0);
    exp_q.delete();
    rst = 1'b0;
    send_bit(1'b1, 0, 0); send_bit(1'b1, 0, 0); send_bit(1'b0, 0, 0);
    send_bit(1'b0, 0, 0); send_bit(1'b1, 0, 0); send_bit(1'b1, 0, 0);
    ps2_data = 1'b1;
    repeat (TIMEOUT + 10) @(negedge clk);
    check("mrst_no_evt", fifo_count, 0);
    exp_q.push_back({2'b00, 8'h1C});
    send_good(8'h1C);
    drain(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
